// File: rtl/stopwatch_controller.sv
// Multi-channel stopwatch controller: synchronises and debounces active-low buttons,
// then runs one STOPPED/RUNNING/LAP state machine per channel with registered outputs.
module stopwatch_controller #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit CLR_WHILE_RUN   = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_CH-1:0]     start_stop_button_i,
    input  logic [N_CH-1:0]     clear_button_i,
    input  logic [N_CH-1:0]     lap_button_i,
    output logic [N_CH-1:0]     en_o,
    output logic [N_CH-1:0]     clr_o,
    output logic [N_CH-1:0]     freeze_o,
    output logic [2*N_CH-1:0]   state_o
);

    localparam int NB = 3 * N_CH;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUNNING = 2'b01,
        ST_LAP     = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    logic [NB-1:0]   raw_s;
    logic [NB-1:0]   sync1_r;
    logic [NB-1:0]   sync2_r;
    logic [NB-1:0]   deb_r;
    logic [NB-1:0]   deb_d_r;
    logic [NB-1:0]   ev_r;
    logic [CW-1:0]   cnt_r [NB];
    logic [N_CH-1:0] ss_ev_s;
    logic [N_CH-1:0] clr_ev_s;
    logic [N_CH-1:0] lap_ev_s;
    state_t          state_r [N_CH];

    // Bit layout: start/stop buttons low, clear buttons middle, lap buttons high.
    assign raw_s    = {lap_button_i, clear_button_i, start_stop_button_i};
    assign ss_ev_s  = ev_r[N_CH-1:0];
    assign clr_ev_s = ev_r[2*N_CH-1:N_CH];
    assign lap_ev_s = ev_r[3*N_CH-1:2*N_CH];

    // Synchroniser, debouncer and registered press-edge detector for every button.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= '1;
            sync2_r <= '1;
            deb_r   <= '1;
            deb_d_r <= '1;
            ev_r    <= '0;
            for (int b = 0; b < NB; b++) begin
                cnt_r[b] <= '0;
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            ev_r    <= deb_d_r & ~deb_r;
            for (int b = 0; b < NB; b++) begin
                if (sync2_r[b] == deb_r[b]) begin
                    cnt_r[b] <= '0;
                end else if (cnt_r[b] == CNT_LAST) begin
                    deb_r[b] <= sync2_r[b];
                    cnt_r[b] <= '0;
                end else begin
                    cnt_r[b] <= cnt_r[b] + CW'(1);
                end
            end
        end
    end

    // Per-channel state machines; priority is clear, then start/stop, then lap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_o     <= '0;
            clr_o    <= '0;
            freeze_o <= '0;
            for (int c = 0; c < N_CH; c++) begin
                state_r[c] <= ST_STOPPED;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                clr_o[c] <= 1'b0;
                case (state_r[c])
                    ST_STOPPED: begin
                        if (clr_ev_s[c]) begin
                            clr_o[c] <= 1'b1;
                        end else if (ss_ev_s[c]) begin
                            state_r[c]  <= ST_RUNNING;
                            en_o[c]     <= 1'b1;
                            freeze_o[c] <= 1'b0;
                        end
                    end
                    ST_RUNNING, ST_LAP: begin
                        if (clr_ev_s[c] && CLR_WHILE_RUN) begin
                            clr_o[c]    <= 1'b1;
                            state_r[c]  <= ST_STOPPED;
                            en_o[c]     <= 1'b0;
                            freeze_o[c] <= 1'b0;
                        end else if (ss_ev_s[c]) begin
                            state_r[c]  <= ST_STOPPED;
                            en_o[c]     <= 1'b0;
                            freeze_o[c] <= 1'b0;
                        end else if (lap_ev_s[c]) begin
                            if (state_r[c] == ST_RUNNING) begin
                                state_r[c]  <= ST_LAP;
                                en_o[c]     <= 1'b1;
                                freeze_o[c] <= 1'b1;
                            end else begin
                                state_r[c]  <= ST_RUNNING;
                                en_o[c]     <= 1'b1;
                                freeze_o[c] <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r[c]  <= ST_STOPPED;
                        en_o[c]     <= 1'b0;
                        freeze_o[c] <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_state_out
        assign state_o[2*c +: 2] = state_r[c];
    end

endmodule
